// File: rtl/bkg_read_arbiter.sv
// Background RAM read arbiter: shares the RAM read port between VGA fetch and aux sampler, applies vertical scroll.
// Optional build macro BKG_AUX_STARVE_GUARD_EN adds a starvation guard that forces an aux grant after STARVE_LIM cycles.
module bkg_read_arbiter #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 160,
  parameter int ADDR_W     = 15,
  parameter int STARVE_LIM = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [7:0]        scroll_step,
  input  logic              pix_req,
  input  logic [7:0]        pix_x,
  input  logic [7:0]        pix_y,
  output logic              pix_valid,
  output logic [23:0]       pix_data,
  input  logic              aux_req,
  input  logic [7:0]        aux_x,
  input  logic [7:0]        aux_y,
  output logic              aux_ack,
  output logic [23:0]       aux_data,
  output logic [ADDR_W-1:0] read_address,
  input  logic [23:0]       ram_data,
  output logic [7:0]        scroll_row
);

  typedef struct packed {
    logic pix;
    logic pix_oor;
    logic pix_rep;
    logic aux;
    logic aux_oor;
  } tag_t;

  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT, A_ACK} aux_state_t;

  if (STARVE_LIM < 1) begin : g_bad_lim
    $error("STARVE_LIM must be at least 1");
  end

  function automatic logic [7:0] scroll_next(input logic [7:0] cur, input logic [7:0] step);
    logic [7:0] s;
    logic [8:0] sum;
    s   = (step > 8'(IMG_H - 1)) ? 8'(IMG_H - 1) : step;
    sum = {1'b0, cur} + {1'b0, s};
    if (sum >= 9'(IMG_H)) sum = sum - 9'(IMG_H);
    return sum[7:0];
  endfunction

  // Row wrap by one conditional subtract; *160 as (row<<7)+(row<<5).
  function automatic logic [ADDR_W-1:0] map_addr(input logic [7:0] x, input logic [7:0] y,
                                                 input logic [7:0] scroll);
    logic [8:0] row;
    row = {1'b0, y} + {1'b0, scroll};
    if (row >= 9'(IMG_H)) row = row - 9'(IMG_H);
    return (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5) + ADDR_W'(x);
  endfunction

  function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
    return (x < 8'(IMG_W)) && (y < 8'(IMG_H));
  endfunction

  aux_state_t  state;
  tag_t        tag_n, tag_p1, tag_p2;
  logic        force_aux, pix_go, aux_go;
  logic        pix_in, aux_in, sel_in;
  logic [7:0]  sel_x, sel_y;
  logic [23:0] last_pix, aux_hold;

`ifdef BKG_AUX_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  logic [CNT_W-1:0] starve_cnt;
  assign force_aux = (state == A_ISSUE) && (starve_cnt >= CNT_W'(STARVE_LIM));
`else
  assign force_aux = 1'b0;
`endif

  assign pix_go = pix_req && !force_aux;
  assign aux_go = (state == A_ISSUE) && (!pix_req || force_aux);
  assign pix_in = in_range(pix_x, pix_y);
  assign aux_in = in_range(aux_x, aux_y);
  assign sel_in = pix_go ? pix_in : aux_in;

  always_comb begin
    sel_x = pix_x;
    sel_y = pix_y;
    if (!pix_go) begin
      sel_x = aux_x;
      sel_y = aux_y;
    end
  end

  // A forced aux grant still tags the displaced pixel so it returns a repeat beat.
  always_comb begin
    tag_n         = '0;
    tag_n.pix     = pix_req;
    tag_n.pix_oor = pix_go && !pix_in;
    tag_n.pix_rep = pix_req && force_aux;
    tag_n.aux     = aux_go;
    tag_n.aux_oor = aux_go && !aux_in;
  end

  // Stage p1: address register with tag; stage p2: tag aligned with ram_data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address <= '0;
      scroll_row   <= '0;
      tag_p1       <= '0;
      tag_p2       <= '0;
    end else begin
      if (frame_start) scroll_row <= scroll_next(scroll_row, scroll_step);
      if ((pix_go || aux_go) && sel_in) read_address <= map_addr(sel_x, sel_y, scroll_row);
      tag_p1 <= tag_n;
      tag_p2 <= tag_p1;
    end
  end

  assign pix_valid = tag_p2.pix;

  always_comb begin
    pix_data = '0;
    if (tag_p2.pix_rep)                 pix_data = last_pix;
    else if (tag_p2.pix && !tag_p2.pix_oor) pix_data = ram_data;
  end

  always_comb begin
    aux_data = aux_hold;
    if (aux_ack) aux_data = (tag_p2.aux && !tag_p2.aux_oor) ? ram_data : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_pix <= '0;
      aux_hold <= '0;
    end else begin
      if (tag_p2.pix) last_pix <= pix_data;
      if (aux_ack)    aux_hold <= aux_data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= A_IDLE;
      aux_ack <= 1'b0;
`ifdef BKG_AUX_STARVE_GUARD_EN
      starve_cnt <= '0;
`endif
    end else begin
      aux_ack <= (state == A_WAIT);
      case (state)
        A_IDLE:  if (aux_req) state <= A_ISSUE;
        A_ISSUE: if (aux_go)  state <= A_WAIT;
        A_WAIT:  state <= A_ACK;
        A_ACK:   state <= A_IDLE;
        default: state <= A_IDLE;
      endcase
`ifdef BKG_AUX_STARVE_GUARD_EN
      if ((state == A_ISSUE) && !aux_go) starve_cnt <= starve_cnt + 1'b1;
      else                               starve_cnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_bkg_read_arbiter.sv
// Self-checking bench for bkg_read_arbiter: vector table, scoreboard queues, and aux contention/reset sequences.
module tb_bkg_read_arbiter;
  localparam int LIM = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [7:0]  scroll_step;
  logic        pix_req;
  logic [7:0]  pix_x, pix_y;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        aux_req;
  logic [7:0]  aux_x, aux_y;
  logic        aux_ack;
  logic [23:0] aux_data;
  logic [14:0] read_address;
  logic [23:0] ram_data;
  logic [7:0]  scroll_row;

  bkg_read_arbiter #(.IMG_W(160), .IMG_H(160), .ADDR_W(15), .STARVE_LIM(LIM)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .scroll_step(scroll_step),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_data(pix_data),
    .aux_req(aux_req), .aux_x(aux_x), .aux_y(aux_y), .aux_ack(aux_ack), .aux_data(aux_data),
    .read_address(read_address), .ram_data(ram_data), .scroll_row(scroll_row)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] mem_fn(input logic [14:0] a);
    return {a[7:0] ^ 8'hC3, 1'b1, a[14:8], a[7:0] + 8'h11};
  endfunction

  function automatic int baddr(input int x, input int y, input int scr);
    return ((y + scr) % 160) * 160 + x;
  endfunction

  always @(posedge Clk) ram_data <= mem_fn(read_address);

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { logic [23:0] data; int due; } exp_t;
  typedef struct {
    logic       fs;
    logic [7:0] step;
    logic [7:0] x, y;
    logic [7:0] exp_scroll;
    logic [14:0] exp_addr;
  } vec_t;

  exp_t pq[$];
  exp_t aq[$];
  exp_t me;
  vec_t vecs[10];
  int checks = 0, errors = 0, aux_acks = 0, m_scr = 0, acks0;
  logic [23:0] last_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_pix(input int x, input int y, input bit rep);
    exp_t e;
    pix_req = 1'b1;
    pix_x   = 8'(x);
    pix_y   = 8'(y);
    e.due   = cyc + 2;
    if (rep)                     e.data = last_exp;
    else if (x >= 160 || y >= 160) e.data = '0;
    else                         e.data = mem_fn(15'(baddr(x, y, m_scr)));
    last_exp = e.data;
    pq.push_back(e);
  endtask

  task automatic push_aux(input int x, input int y, input int lat);
    exp_t e;
    e.due  = cyc + lat;
    e.data = (x >= 160 || y >= 160) ? 24'h0 : mem_fn(15'(baddr(x, y, m_scr)));
    aq.push_back(e);
  endtask

  task automatic frame(input logic [7:0] step);
    frame_start = 1'b1;
    scroll_step = step;
    m_scr = (m_scr + ((step > 159) ? 159 : int'(step))) % 160;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!aux_ack && n < 20) begin
      tick();
      n++;
    end
    chk("aux_ack_timeout", 32'(aux_ack), 1);
    aux_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   15'd0};
    vecs[1] = '{1'b1, 8'd100, 8'd10,  8'd20,  8'd100, 15'd19210};
    vecs[2] = '{1'b1, 8'd100, 8'd5,   8'd130, 8'd40,  15'd1605};
    vecs[3] = '{1'b0, 8'd0,   8'd159, 8'd119, 8'd40,  15'd25599};
    vecs[4] = '{1'b0, 8'd0,   8'd160, 8'd3,   8'd40,  15'd25599};
    vecs[5] = '{1'b0, 8'd0,   8'd3,   8'd160, 8'd40,  15'd25599};
    vecs[6] = '{1'b1, 8'd200, 8'd7,   8'd121, 8'd39,  15'd7};
    vecs[7] = '{1'b1, 8'd121, 8'd1,   8'd1,   8'd0,   15'd161};
    vecs[8] = '{1'b1, 8'd200, 8'd2,   8'd2,   8'd159, 15'd162};
    vecs[9] = '{1'b1, 8'd1,   8'd4,   8'd159, 8'd0,   15'd25444};

    Reset = 1'b1; frame_start = 1'b0; scroll_step = '0; pix_req = 1'b0; pix_x = '0; pix_y = '0;
    aux_req = 1'b0; aux_x = '0; aux_y = '0;

    fork
      forever begin
        @(negedge Clk);
        if (pq.size() > 0 && pq[0].due < cyc) begin
          me = pq.pop_front();
          chk("pix_missing_due", 32'(cyc), 32'(me.due));
        end
        if (pix_valid) begin
          if (pq.size() == 0) chk("pix_unexpected", 32'(pix_valid), 0);
          else begin
            me = pq.pop_front();
            chk("pix_data", 32'(pix_data), 32'(me.data));
            chk("pix_latency", 32'(cyc), 32'(me.due));
          end
        end
        if (aq.size() > 0 && aq[0].due < cyc) begin
          me = aq.pop_front();
          chk("aux_missing_due", 32'(cyc), 32'(me.due));
        end
        if (aux_ack) begin
          aux_acks++;
          if (aq.size() == 0) chk("aux_unexpected", 32'(aux_ack), 0);
          else begin
            me = aq.pop_front();
            chk("aux_data", 32'(aux_data), 32'(me.data));
            chk("aux_latency", 32'(cyc), 32'(me.due));
          end
        end
      end
    join_none

    repeat (3) tick();
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_aux_ack", 32'(aux_ack), 0);
    chk("rst_pix_data", 32'(pix_data), 0);
    chk("rst_aux_data", 32'(aux_data), 0);
    chk("rst_read_address", 32'(read_address), 0);
    chk("rst_scroll_row", 32'(scroll_row), 0);
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].fs) frame(vecs[i].step);
      tick();
      frame_start = 1'b0;
      chk($sformatf("vec%0d_scroll", i), 32'(scroll_row), 32'(vecs[i].exp_scroll));
      drive_pix(int'(vecs[i].x), int'(vecs[i].y), 1'b0);
      tick();
      pix_req = 1'b0;
      chk($sformatf("vec%0d_addr", i), 32'(read_address), 32'(vecs[i].exp_addr));
    end
    tick();

    // frame_start in the same cycle as a request: old scroll for that request
    drive_pix(10, 150, 1'b0);
    frame(8'd30);
    tick();
    frame_start = 1'b0;
    chk("coinc_addr_old", 32'(read_address), 24010);
    chk("coinc_scroll", 32'(scroll_row), 30);
    drive_pix(10, 150, 1'b0);
    tick();
    pix_req = 1'b0;
    chk("coinc_addr_new", 32'(read_address), 3210);
    tick();

    // minimum aux turnaround
    aux_req = 1'b1; aux_x = 8'd12; aux_y = 8'd7;
    push_aux(12, 7, 3);
    wait_ack();
    chk("aux_addr", 32'(read_address), 5932);
    tick();

    // aux out of range: completes with zero data, address untouched
    aux_req = 1'b1; aux_x = 8'd5; aux_y = 8'd200;
    push_aux(5, 200, 3);
    wait_ack();
    chk("aux_oor_addr", 32'(read_address), 5932);
    tick();

    // aux against continuous pixel traffic
    acks0 = aux_acks;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin
        aux_req = 1'b1; aux_x = 8'd50; aux_y = 8'd60;
      end
`ifdef BKG_AUX_STARVE_GUARD_EN
      if (i == 7) begin
        drive_pix((i * 13) % 160, (i * 29 + 3) % 160, 1'b1);
        push_aux(50, 60, 2);
      end else drive_pix((i * 13) % 160, (i * 29 + 3) % 160, 1'b0);
      tick();
      if (i == 7) chk("guard_forced_addr", 32'(read_address), 14450);
      if (aux_ack) aux_req = 1'b0;
`else
      drive_pix((i * 13) % 160, (i * 29 + 3) % 160, 1'b0);
      tick();
`endif
    end
    pix_req = 1'b0;
`ifdef BKG_AUX_STARVE_GUARD_EN
    chk("guard_acks", 32'(aux_acks - acks0), 1);
    tick();
`else
    chk("starved_acks", 32'(aux_acks - acks0), 0);
    push_aux(50, 60, 2);
    wait_ack();
    tick();
`endif
    tick();

    // reset in the middle of an aux read and a pixel request
    aux_req = 1'b1; aux_x = 8'd20; aux_y = 8'd20;
    tick();
    tick();
    aux_req = 1'b0;
    pix_req = 1'b1; pix_x = 8'd15; pix_y = 8'd15;
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_read_address", 32'(read_address), 0);
    chk("mid_rst_scroll_row", 32'(scroll_row), 0);
    chk("mid_rst_pix_valid", 32'(pix_valid), 0);
    chk("mid_rst_aux_ack", 32'(aux_ack), 0);
    chk("mid_rst_aux_data", 32'(aux_data), 0);
    chk("mid_rst_pix_data", 32'(pix_data), 0);
    pq.delete();
    aq.delete();
    m_scr = 0;
    #3;
    pix_req = 1'b0;
    Reset = 1'b0;
    repeat (4) tick();
    chk("post_rst_pix_valid", 32'(pix_valid), 0);
    chk("post_rst_aux_ack", 32'(aux_ack), 0);

    repeat (3) tick();
    chk("pix_queue_drained", 32'(pq.size()), 0);
    chk("aux_queue_drained", 32'(aq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bkg_read_arbiter.md
# bkg_read_arbiter

Read-side controller for the 160x160, 24-bit background RAM (1-cycle synchronous read). It owns the RAM's single `read_address` port and shares it between the VGA pixel fetch path and an auxiliary game-logic sampler used for platform/collision probes. It also applies the vertical scroll offset that makes the background wrap as the player climbs. The block sits between the color mapper/VGA pipeline and the background RAM instance.

## Interface
- `IMG_W`, 160: image width in pixels.
- `IMG_H`, 160: image height in rows.
- `ADDR_W`, 15: RAM address width.
- `STARVE_LIM`, 64: aux wait cycles before a forced grant (guard build only).

- `Clk`  in  1  system clock; all state on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse at the start of vertical blank.
- `scroll_step`  in  8  rows to advance the scroll at `frame_start`.
- `pix_req`  in  1  VGA fetch request, one per cycle, no handshake.
- `pix_x`, `pix_y`  in  8 each  VGA image coordinates.
- `pix_valid`  out  1  `pix_data` valid.
- `pix_data`  out  24  RGB for the request issued 2 cycles earlier.
- `aux_req`  in  1  aux request; held until `aux_ack`.
- `aux_x`, `aux_y`  in  8 each  aux coordinates; stable while `aux_req` is high.
- `aux_ack`  out  1  one-cycle pulse; `aux_data` valid in the same cycle.
- `aux_data`  out  24  sampled RGB.
- `read_address`  out  `ADDR_W`  registered address to the RAM.
- `ram_data`  in  24  RAM read data (1 cycle after `read_address`).
- `scroll_row`  out  8  current scroll offset, for debug.

## Operation
- Scroll: `scroll_row` is in 0..IMG_H-1. On `frame_start`, `scroll_row <= (scroll_row + min(scroll_step, IMG_H-1)) mod IMG_H`, computed with a single conditional subtract.
- Address: `((y + scroll_row) mod IMG_H) * IMG_W + x`, where (x, y) come from the granted requester. Compute it with 9-bit sum, conditional subtract, and shift-add (`*160 = <<7 + <<5`).
- Out-of-range coordinates (x ≥ IMG_W or y ≥ IMG_H): no RAM access is made (address unchanged). The request still completes, with data `24'h000000`.
- Arbitration: `pix_req` has strict priority. Aux is granted only in a cycle with `pix_req` low.
- Aux FSM:
  - A_IDLE: go to A_ISSUE when `aux_req` is high.
  - A_ISSUE: wait for a grant. On grant, drive the address and go to A_WAIT.
  - A_WAIT: RAM latency cycle.
  - A_ACK: capture `ram_data`, pulse `aux_ack`, return to A_IDLE.
  - `aux_req` must be low in the cycle after `aux_ack`. If it is still high, that counts as a new request.
- A request tag (pix / aux / oor) travels down a 2-stage shift register alongside the address, so returned data is steered to the correct output.

## Timing
- Request at cycle N → `read_address` registered at N+1 → `ram_data` at N+2 → `pix_valid` / `aux_ack` asserted at N+2 with registered data. Fixed latency 2.
- `pix_req` held high continuously gives one `pix_valid` per cycle, back-to-back.
- Minimum aux turnaround from `aux_req` rise to `aux_ack`: 3 cycles (A_ISSUE granted immediately).
- `frame_start` coincident with a request: that request uses the old `scroll_row`. The new value applies from N+1.
- Reset (any time, including mid-transaction) clears all of the following immediately; in-flight reads are dropped:
  - `pix_valid`, `aux_ack`, `pix_data`, `aux_data`, `read_address`, `scroll_row`, and the tag pipe → 0
  - FSM → A_IDLE

## Configuration
- `BKG_AUX_STARVE_GUARD_EN` defined:
  - A counter increments each cycle in A_ISSUE without a grant.
  - On reaching `STARVE_LIM`, aux is granted over `pix_req` for one cycle. The dropped pixel returns `pix_valid`=1 with `pix_data` repeating the previous pixel value.
  - The counter clears on grant.
- Undefined: strict pix priority. Aux may starve indefinitely; no counter logic is synthesized.

## Test plan
- Reset, then `pix_req` at (0,0) with `scroll_row`=0 → `read_address`=0 at N+1; `pix_valid`=1 and `pix_data`=mem[0] at N+2.
- Scroll wrap: `scroll_step`=100 applied at two `frame_start` pulses → `scroll_row`=40. Then pix (5,130) → address ((130+40)-160)*160+5 = 1605.
- `scroll_step`=200 at `frame_start` from 0 → `scroll_row`=159.
- Aux during continuous `pix_req` for 10 cycles, then `pix_req` low → `aux_ack` exactly 2 cycles after the first idle cycle, with `aux_data`=mem[addr]. No pix beat is lost.
- Out of range: pix (160,3) → `pix_valid` at N+2 with `pix_data`=0, and `read_address` unchanged.
- Guard build, `STARVE_LIM`=4, `pix_req` held high → aux granted on the 5th cycle in A_ISSUE, and that pixel repeats the previous data. In a non-guard build → `aux_ack` never asserts.
